// File: rtl/track_sequencer.sv
// Centroid track sequencer: acquires a target over consecutive valid frames,
// follows it while the centroid is valid and coasts on the last aim point after loss.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no target; waiting for a frame with a valid centroid
// S_ACQUIRE | counting consecutive valid frames toward lock
// S_TRACK   | locked; aim follows the centroid every valid cycle
// S_COAST   | centroid lost; aim held until recovery or coast timeout
module track_sequencer #(
    parameter int clock_frequency_mhz     = 50,
    parameter int coast_time_milliseconds = 500,
    parameter int acq_frames              = 3,
    parameter int coord_width             = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   oCent_Val,
    input  logic [coord_width-1:0] oCent_X,
    input  logic [coord_width-1:0] oCent_Y,
    output logic [coord_width-1:0] aim_x,
    output logic [coord_width-1:0] aim_y,
    output logic                   aim_valid,
    output logic [1:0]             trk_state,
    output logic                   lost
);

    localparam int COAST_CYCLES = clock_frequency_mhz * 1000 * coast_time_milliseconds;
    localparam int CNT_W        = $clog2(COAST_CYCLES) + 1;
    localparam logic [CNT_W-1:0] COAST_LAST = CNT_W'(COAST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       ACQ_N      = 4'(acq_frames);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_TRACK   = 2'd2,
        S_COAST   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_hit_cnt;
    logic [3:0]             w_hit_nxt;
    logic [CNT_W-1:0]       r_coast_cnt;
    logic [CNT_W-1:0]       w_coast_nxt;
    logic [coord_width-1:0] r_aim_x;
    logic [coord_width-1:0] r_aim_y;
    logic [coord_width-1:0] w_aim_x_nxt;
    logic [coord_width-1:0] w_aim_y_nxt;
    logic                   r_aim_valid;
    logic                   w_aim_valid_nxt;
    logic                   r_lost;
    logic                   w_lost_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hit_cnt   <= 4'd0;
            r_coast_cnt <= '0;
            r_aim_x     <= '0;
            r_aim_y     <= '0;
            r_aim_valid <= 1'b0;
            r_lost      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hit_cnt   <= w_hit_nxt;
            r_coast_cnt <= w_coast_nxt;
            r_aim_x     <= w_aim_x_nxt;
            r_aim_y     <= w_aim_y_nxt;
            r_aim_valid <= w_aim_valid_nxt;
            r_lost      <= w_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hit_nxt   = r_hit_cnt;
        w_coast_nxt = r_coast_cnt;
        w_aim_x_nxt = r_aim_x;
        w_aim_y_nxt = r_aim_y;
        w_lost_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (frame_start && oCent_Val) begin
                    w_hit_nxt = 4'd1;
                    if (ACQ_N <= 4'd1) begin
                        w_state_nxt = S_TRACK;
                        w_aim_x_nxt = oCent_X;
                        w_aim_y_nxt = oCent_Y;
                    end else begin
                        w_state_nxt = S_ACQUIRE;
                    end
                end
            end
            S_ACQUIRE: begin
                if (frame_start) begin
                    if (oCent_Val) begin
                        // hit_cnt < ACQ_N <= 15 here, so the increment cannot overflow
                        if ((r_hit_cnt + 4'd1) >= ACQ_N) begin
                            w_hit_nxt   = ACQ_N;
                            w_state_nxt = S_TRACK;
                            w_aim_x_nxt = oCent_X;
                            w_aim_y_nxt = oCent_Y;
                        end else begin
                            w_hit_nxt = r_hit_cnt + 4'd1;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_hit_nxt   = 4'd0;
                    end
                end
            end
            S_TRACK: begin
                if (oCent_Val) begin
                    w_aim_x_nxt = oCent_X;
                    w_aim_y_nxt = oCent_Y;
                end else begin
                    w_state_nxt = S_COAST;
                    w_coast_nxt = '0;
                end
            end
            S_COAST: begin
                // Recovery takes priority over a coincident timeout
                if (oCent_Val) begin
                    w_state_nxt = S_TRACK;
                    w_coast_nxt = '0;
                    w_aim_x_nxt = oCent_X;
                    w_aim_y_nxt = oCent_Y;
                end else if (r_coast_cnt == COAST_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_coast_nxt = '0;
                    w_hit_nxt   = 4'd0;
                    w_lost_nxt  = 1'b1;
                end else begin
                    w_coast_nxt = r_coast_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_aim_valid_nxt = (w_state_nxt == S_TRACK) || (w_state_nxt == S_COAST);
    end

    assign aim_x     = r_aim_x;
    assign aim_y     = r_aim_y;
    assign aim_valid = r_aim_valid;
    assign trk_state = r_state;
    assign lost      = r_lost;

endmodule

// File: tb/tb_track_sequencer.sv
// Scoreboard bench for track_sequencer: directed steps queue hand-computed
// expected outputs; a monitor pops and compares them after each clock edge.
module tb_track_sequencer;

    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          oCent_Val = 1'b0;
    logic [CW-1:0] oCent_X = '0;
    logic [CW-1:0] oCent_Y = '0;
    logic [CW-1:0] aim_x;
    logic [CW-1:0] aim_y;
    logic          aim_valid;
    logic [1:0]    trk_state;
    logic          lost;

    track_sequencer #(
        .clock_frequency_mhz    (1),
        .coast_time_milliseconds(1),
        .acq_frames             (3),
        .coord_width            (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .oCent_Val  (oCent_Val),
        .oCent_X    (oCent_X),
        .oCent_Y    (oCent_Y),
        .aim_x      (aim_x),
        .aim_y      (aim_y),
        .aim_valid  (aim_valid),
        .trk_state  (trk_state),
        .lost       (lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int            cyc;
        logic [1:0]    st;
        logic [CW-1:0] ax;
        logic [CW-1:0] ay;
        logic          av;
        logic          lst;
        logic          ck_aim;
        string         name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic exp_t mk(input logic [1:0] st, input logic [CW-1:0] ax,
                                input logic [CW-1:0] ay, input logic av,
                                input logic lst, input logic ck, input string name);
        exp_t e;
        e.cyc    = 0;
        e.st     = st;
        e.ax     = ax;
        e.ay     = ay;
        e.av     = av;
        e.lst    = lst;
        e.ck_aim = ck;
        e.name   = name;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        logic ok;
        n_checks = n_checks + 1;
        ok = (trk_state === e.st) && (aim_valid === e.av) && (lost === e.lst) &&
             (!e.ck_aim || ((aim_x === e.ax) && (aim_y === e.ay)));
        if (!ok) begin
            n_err = n_err + 1;
            $display("FAIL %s cyc=%0d: got st=%0d aim=(%0d,%0d) av=%0b lost=%0b, want st=%0d aim=(%0d,%0d) av=%0b lost=%0b",
                     e.name, cyc, trk_state, aim_x, aim_y, aim_valid, lost,
                     e.st, e.ax, e.ay, e.av, e.lst);
        end
    endtask

    // Monitor: every expectation tagged with the current edge count is checked
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.cyc < cyc) begin
                    n_checks = n_checks + 1;
                    n_err    = n_err + 1;
                    $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
                end else begin
                    compare(e);
                end
            end
        end
    end

    task automatic step(input logic fs, input logic v, input logic [CW-1:0] x,
                        input logic [CW-1:0] y, input exp_t e_in);
        exp_t e;
        @(negedge clk);
        frame_start = fs;
        oCent_Val   = v;
        oCent_X     = x;
        oCent_Y     = y;
        e     = e_in;
        e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    initial begin
        // Reset state, before any clock edge
        #3;
        compare(mk(2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, "reset_state"));
        @(negedge clk);
        #2 rst = 1'b0;

        // Idle holds without a full (frame_start & valid) event
        step(1'b1, 1'b0, 10'd1, 10'd2, mk(2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, "idle_fs_noval"));
        step(1'b0, 1'b1, 10'd1, 10'd2, mk(2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, "idle_val_nofs"));

        // Acquisition: three valid frames to lock at (100,200)
        step(1'b1, 1'b1, 10'd100, 10'd200, mk(2'd1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, "acq_hit1"));
        step(1'b0, 1'b1, 10'd100, 10'd200, mk(2'd1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, "acq_nofs"));
        step(1'b1, 1'b1, 10'd100, 10'd200, mk(2'd1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, "acq_hit2"));
        step(1'b0, 1'b1, 10'd100, 10'd200, mk(2'd1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, "acq_nofs2"));
        step(1'b1, 1'b1, 10'd100, 10'd200, mk(2'd2, 10'd100, 10'd200, 1'b1, 1'b0, 1'b1, "lock"));
        step(1'b1, 1'b1, 10'd100, 10'd200, mk(2'd2, 10'd100, 10'd200, 1'b1, 1'b0, 1'b1, "track_fs_ignored"));

        // 500-cycle gap, then recovery at (300,310); frame_start ignored in coast
        for (int i = 0; i < 500; i++)
            step((i == 10) ? 1'b1 : 1'b0, 1'b0, 10'd555, 10'd555,
                 mk(2'd3, 10'd100, 10'd200, 1'b1, 1'b0, 1'b1, "coast_gap"));
        step(1'b0, 1'b1, 10'd300, 10'd310, mk(2'd2, 10'd300, 10'd310, 1'b1, 1'b0, 1'b1, "recover"));
        step(1'b0, 1'b1, 10'd300, 10'd310, mk(2'd2, 10'd300, 10'd310, 1'b1, 1'b0, 1'b1, "recover_hold"));

        // Valid raised on the exact timeout edge: track wins, no lost
        for (int i = 0; i < 1000; i++)
            step(1'b0, 1'b0, 10'd777, 10'd777, mk(2'd3, 10'd300, 10'd310, 1'b1, 1'b0, 1'b1, "coast_to_edge"));
        step(1'b0, 1'b1, 10'd400, 10'd410, mk(2'd2, 10'd400, 10'd410, 1'b1, 1'b0, 1'b1, "timeout_race"));
        step(1'b0, 1'b1, 10'd400, 10'd410, mk(2'd2, 10'd400, 10'd410, 1'b1, 1'b0, 1'b1, "race_no_lost"));

        // Permanent loss: 1000 coast cycles, then one-cycle lost and idle
        for (int i = 0; i < 1000; i++)
            step(1'b0, 1'b0, 10'd777, 10'd777, mk(2'd3, 10'd400, 10'd410, 1'b1, 1'b0, 1'b1, "coast_full"));
        step(1'b0, 1'b0, 10'd777, 10'd777, mk(2'd0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, "timeout_lost"));
        step(1'b0, 1'b0, 10'd777, 10'd777, mk(2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, "lost_one_cycle"));

        // Abort after two hits, then a fresh three-frame acquisition
        step(1'b1, 1'b1, 10'd50, 10'd60, mk(2'd1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, "reacq_hit1"));
        step(1'b1, 1'b1, 10'd50, 10'd60, mk(2'd1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, "reacq_hit2"));
        step(1'b1, 1'b0, 10'd50, 10'd60, mk(2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, "acq_abort"));
        step(1'b1, 1'b1, 10'd70, 10'd80, mk(2'd1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, "after_abort_hit1"));
        step(1'b1, 1'b1, 10'd70, 10'd80, mk(2'd1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, "after_abort_hit2"));
        step(1'b1, 1'b1, 10'd70, 10'd80, mk(2'd2, 10'd70, 10'd80, 1'b1, 1'b0, 1'b1, "after_abort_lock"));

        // Asynchronous reset mid-coast
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, 10'd555, 10'd555, mk(2'd3, 10'd70, 10'd80, 1'b1, 1'b0, 1'b1, "coast_pre_reset"));
        @(negedge clk);
        frame_start = 1'b0;
        #2 rst = 1'b1;
        #1 compare(mk(2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, "async_reset"));
        @(posedge clk);
        #1 compare(mk(2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, "held_reset"));
        @(negedge clk);
        #2 rst = 1'b0;
        step(1'b0, 1'b1, 10'd90, 10'd95, mk(2'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, "post_reset_idle"));
        step(1'b1, 1'b1, 10'd90, 10'd95, mk(2'd1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, "post_reset_hit1"));
        step(1'b1, 1'b1, 10'd90, 10'd95, mk(2'd1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, "post_reset_hit2"));
        step(1'b1, 1'b1, 10'd90, 10'd95, mk(2'd2, 10'd90, 10'd95, 1'b1, 1'b0, 1'b1, "post_reset_lock"));
        step(1'b0, 1'b1, 10'd90, 10'd95, mk(2'd2, 10'd90, 10'd95, 1'b1, 1'b0, 1'b1, "post_reset_track"));

        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_checks = n_checks + 1;
            n_err    = n_err + 1;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
